// File: rtl/handshake_pkg.sv
// Shared helpers for the handshake fabric buffers.
//
// Contents:
//   clog2()     - ceiling log2 usable in constant expressions
//   ptr_width() - width of a slot index for an n-slot FIFO (never below 1)
//   cnt_width() - width of an occupancy counter able to hold 0..n
package handshake_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_NUM_SLOTS  = 4;

  // Smallest r with 2**r >= value; clog2(0) = clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // A single-slot FIFO still needs a one-bit pointer so the ports stay legal.
  function automatic int unsigned ptr_width(input int unsigned num_slots);
    return (clog2(num_slots) < 1) ? 1 : clog2(num_slots);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned num_slots);
    return clog2(num_slots + 1);
  endfunction

endpackage

// File: rtl/handshake_fifo_mem.sv
// Register-file storage for handshake_fifo_buffer.
//
// Ports:
//   clk   - rising-edge clock
//   we    - write enable, writes wdata to slot waddr at the clock edge
//   waddr - write slot index
//   wdata - write data
//   raddr - read slot index (asynchronous read)
//   rdata - contents of slot raddr
//
// Contents are deliberately not reset; the owning FIFO never presents a slot
// that has not been written since its last reset.
module handshake_fifo_mem
  import handshake_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned NUM_SLOTS  = DEFAULT_NUM_SLOTS,
  parameter int unsigned PW         = ptr_width(NUM_SLOTS)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [PW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [PW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [NUM_SLOTS];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/handshake_fifo_buffer.sv
// Opaque elastic FIFO for the valid/ready dataflow fabric.
//
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous active-high reset
//   ins        - incoming token data
//   ins_valid  - producer offers a token
//   ins_ready  - buffer has a free slot (depends on registered state only)
//   outs       - head-of-FIFO data (don't-care while outs_valid is low)
//   outs_valid - a head token is present (depends on registered state only)
//   outs_ready - consumer accepts the head token
//
// Handshake: a token moves across an interface in any cycle where both valid
// and ready are high at the rising edge. Neither ready nor valid produced here
// looks at the opposite side's inputs, so no combinational path crosses the
// buffer and a token written in cycle N is first visible in cycle N+1.
module handshake_fifo_buffer
  import handshake_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned NUM_SLOTS  = DEFAULT_NUM_SLOTS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  localparam int unsigned PW = ptr_width(NUM_SLOTS);
  localparam int unsigned CW = cnt_width(NUM_SLOTS);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic full, empty, push, pop;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(NUM_SLOTS - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full       = (count_q == CW'(NUM_SLOTS));
  assign empty      = (count_q == '0);
  assign ins_ready  = !full;
  assign outs_valid = !empty;
  assign push       = ins_valid && ins_ready;
  assign pop        = outs_valid && outs_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = ptr_next(tail_q);
    if (pop)  head_d = ptr_next(head_q);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // A push in a reset cycle must not leave a stale write behind.
  handshake_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_SLOTS  (NUM_SLOTS),
    .PW         (PW)
  ) u_mem (
    .clk   (clk),
    .we    (push && !rst),
    .waddr (tail_q),
    .wdata (ins),
    .raddr (head_q),
    .rdata (outs)
  );

endmodule

// File: tb/tb_handshake_fifo_buffer.sv
module tb_handshake_fifo_buffer;

  localparam int DW = 32;
  localparam int NS = 4;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] ins = '0;
  logic          ins_valid = 1'b0;
  logic          ins_ready;
  logic [DW-1:0] outs;
  logic          outs_valid;
  logic          outs_ready = 1'b0;

  always #5 clk = ~clk;

  handshake_fifo_buffer #(.DATA_WIDTH(DW), .NUM_SLOTS(NS)) dut (
    .clk        (clk),
    .rst        (rst),
    .ins        (ins),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .outs       (outs),
    .outs_valid (outs_valid),
    .outs_ready (outs_ready)
  );

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];     // reference FIFO contents, head at index 0
  logic [DW-1:0] popped_q[$];  // tokens observed leaving the DUT
  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Drives one cycle (called just after a rising edge), optionally checks the
  // DUT outputs against the reference FIFO, then advances the reference by the
  // transfer rules across the next edge.
  task automatic step(input logic r, input logic [DW-1:0] d, input logic iv,
                      input logic ordy, input bit do_chk, input string tag);
    int  n;
    bit  will_pop, will_push;
    rst        = r;
    ins        = d;
    ins_valid  = iv;
    outs_ready = ordy;
    #1;
    n = exp_q.size();
    if (do_chk) begin
      chk({tag, ".outs_valid"}, DW'(outs_valid), DW'(n > 0));
      chk({tag, ".ins_ready"},  DW'(ins_ready),  DW'(n < NS));
      if (n > 0) chk({tag, ".outs"}, outs, exp_q[0]);
    end
    will_pop  = (n > 0) && ordy;
    will_push = (n < NS) && iv;
    if (!r && outs_valid === 1'b1 && ordy) popped_q.push_back(outs);
    @(posedge clk);
    if (r) begin
      exp_q.delete();
    end else begin
      if (will_pop)  void'(exp_q.pop_front());
      if (will_push) exp_q.push_back(d);
    end
    #1;
  endtask

  initial begin
    // Reset then idle
    step(1'b1, '0, 1'b0, 1'b0, 1'b0, "rst");
    step(1'b1, '0, 1'b0, 1'b0, 1'b0, "rst");
    chk("reset.outs_valid", DW'(outs_valid), '0);
    chk("reset.ins_ready",  DW'(ins_ready),  DW'(1));
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1, "idle");

    // Single token, one-cycle latency then gone
    step(1'b0, 32'h5AE, 1'b1, 1'b1, 1'b1, "single");
    chk("single.outs", outs, 32'h5AE);
    chk("single.valid", DW'(outs_valid), DW'(1));
    step(1'b0, '0, 1'b0, 1'b1, 1'b1, "single");
    chk("single.gone", DW'(outs_valid), '0);

    // Fill to full, stall a 5th, then drain in order
    for (int i = 1; i <= NS; i++) step(1'b0, DW'(i), 1'b1, 1'b0, 1'b1, "fill");
    chk("fill.full", DW'(ins_ready), '0);
    step(1'b0, 32'd5, 1'b1, 1'b0, 1'b1, "stall");
    chk("stall.still_full", DW'(ins_ready), '0);
    popped_q.delete();
    step(1'b0, '0, 1'b0, 1'b1, 1'b1, "drain");
    chk("drain.ready_after_pop", DW'(ins_ready), DW'(1));
    for (int i = 0; i < NS; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b1, "drain");
    chk("drain.count", DW'(popped_q.size()), DW'(NS));
    for (int i = 0; i < popped_q.size(); i++) chk("drain.order", popped_q[i], DW'(i + 1));

    // Streaming with wrap: 0..9 at one per cycle
    popped_q.delete();
    for (int i = 0; i < 10; i++) begin
      step(1'b0, DW'(i), 1'b1, 1'b1, 1'b1, "stream");
      chk("stream.latency", outs, DW'(i));
    end
    step(1'b0, '0, 1'b0, 1'b1, 1'b1, "stream");
    chk("stream.count", DW'(popped_q.size()), DW'(10));

    // Full-state simultaneous pop and push
    for (int i = 1; i <= NS; i++) step(1'b0, DW'(i), 1'b1, 1'b0, 1'b1, "sim_fill");
    popped_q.delete();
    step(1'b0, 32'd5, 1'b1, 1'b1, 1'b1, "sim_pp");
    chk("sim_pp.ready", DW'(ins_ready), DW'(1));
    step(1'b0, 32'd5, 1'b1, 1'b1, 1'b1, "sim_pp");
    for (int i = 0; i < NS; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b1, "sim_drain");
    chk("sim.count", DW'(popped_q.size()), DW'(5));
    for (int i = 0; i < popped_q.size(); i++) chk("sim.order", popped_q[i], DW'(i + 1));

    // Reset mid-operation with a token offered in the reset cycle
    for (int i = 0; i < 3; i++) step(1'b0, DW'(32'hA0 + i), 1'b1, 1'b0, 1'b1, "mid_fill");
    step(1'b1, 32'hDEAD, 1'b1, 1'b0, 1'b0, "mid_rst");
    chk("mid_rst.outs_valid", DW'(outs_valid), '0);
    chk("mid_rst.ins_ready",  DW'(ins_ready),  DW'(1));
    step(1'b0, '0, 1'b0, 1'b1, 1'b1, "mid_idle");
    for (int i = 1; i <= NS; i++) step(1'b0, DW'(32'hB0 + i), 1'b1, 1'b0, 1'b1, "mid_refill");
    chk("mid_refill.full", DW'(ins_ready), '0);
    for (int i = 0; i < NS; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b1, "mid_drain");

    // Randomized traffic against the reference FIFO
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) == 0), DW'($urandom), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 2) != 0), 1'b1, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
